// File: rtl/decrypt_if.sv
// Handshake and memory-port bundle between the RC4 PRGA stage and its
// controller / S RAM / encrypted ROM / decrypted RAM.
interface decrypt_if;
  logic       start;
  logic       finished;
  logic [7:0] read_data;
  logic       write_en_s;
  logic [7:0] data;
  logic [7:0] address_s;
  logic [7:0] address_e;
  logic       write_en_d;
  logic [7:0] read_encrypt_data;

  modport master (
    output start, read_data, read_encrypt_data,
    input  finished, write_en_s, data, address_s, address_e, write_en_d
  );

  modport slave (
    input  start, read_data, read_encrypt_data,
    output finished, write_en_s, data, address_s, address_e, write_en_d
  );
endinterface

// File: rtl/decrypt.sv
// RC4 PRGA stage: per message byte advances i/j, swaps S[i]/S[j] in the
// external S RAM, reads the keystream byte and writes it XOR ciphertext out.
module decrypt #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  decrypt_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, INC, ADDR_I, WAIT_I, READ_I, ADDR_J, WAIT_J, READ_J,
    WR_I, WR_J, ADDR_F, WAIT_F, READ_F, WR_D, NEXT, DONE
  } state_t;

  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d;

  logic       finished_q, finished_d;
  logic       wes_q, wes_d, wed_q, wed_d;
  logic [7:0] data_q, data_d;
  logic [7:0] addr_s_q, addr_s_d, addr_e_q, addr_e_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      f_q        <= '0;
      finished_q <= 1'b0;
      wes_q      <= 1'b0;
      wed_q      <= 1'b0;
      data_q     <= '0;
      addr_s_q   <= '0;
      addr_e_q   <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      finished_q <= finished_d;
      wes_q      <= wes_d;
      wed_q      <= wed_d;
      data_q     <= data_d;
      addr_s_q   <= addr_s_d;
      addr_e_q   <= addr_e_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    finished_d = 1'b0;
    wes_d      = 1'b0;
    wed_d      = 1'b0;
    data_d     = data_q;
    addr_s_d   = addr_s_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = INC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      INC: begin
        i_d     = i_q + 8'd1;
        state_d = ADDR_I;
      end
      ADDR_I: state_d = WAIT_I;
      WAIT_I: state_d = READ_I;
      READ_I: begin
        si_d    = bus.read_data;
        j_d     = j_q + bus.read_data;
        state_d = ADDR_J;
      end
      ADDR_J: state_d = WAIT_J;
      WAIT_J: state_d = READ_J;
      READ_J: begin
        sj_d    = bus.read_data;
        state_d = WR_I;
      end
      WR_I:   state_d = WR_J;
      WR_J:   state_d = ADDR_F;
      ADDR_F: state_d = WAIT_F;
      WAIT_F: state_d = READ_F;
      READ_F: begin
        f_d     = bus.read_data;
        state_d = WR_D;
      end
      WR_D:   state_d = NEXT;
      NEXT: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = INC;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered against the state being entered, so they use the
    // freshly computed next values; address_s is held through WAIT/READ.
    // The ROM value is taken one cycle early: address_e has been stable since INC.
    case (state_d)
      ADDR_I: addr_s_d = i_d;
      ADDR_J: addr_s_d = j_d;
      WR_I: begin
        addr_s_d = i_d;
        data_d   = sj_d;
        wes_d    = 1'b1;
      end
      WR_J: begin
        addr_s_d = j_d;
        data_d   = si_d;
        wes_d    = 1'b1;
      end
      ADDR_F: addr_s_d = si_d + sj_d;
      WR_D: begin
        data_d = f_d ^ bus.read_encrypt_data;
        wed_d  = 1'b1;
      end
      DONE:   finished_d = 1'b1;
      default: ;
    endcase

    addr_e_d = k_d;
  end

  assign bus.finished   = finished_q;
  assign bus.write_en_s = wes_q;
  assign bus.write_en_d = wed_q;
  assign bus.data       = data_q;
  assign bus.address_s  = addr_s_q;
  assign bus.address_e  = addr_e_q;

endmodule

// File: tb/tb_decrypt.sv
// Bench for decrypt: behavioural memories plus a plain RC4 PRGA reference model.
module tb_decrypt;
  localparam int unsigned MSG_LEN = 32;
  localparam int BYTE_CYC = 14;
  localparam int JOB_CYC  = MSG_LEN * BYTE_CYC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decrypt_if bus ();
  decrypt #(.MSG_LEN(MSG_LEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [7:0] smem [256];
  logic [7:0] emem [256];
  logic [7:0] dmem [256];
  logic [7:0] ld_s [256];
  logic [7:0] ld_e [256];
  logic [7:0] ld_d [256];
  logic       ld_en = 1'b0;
  logic [7:0] s_rd, e_rd;
  bit         cmode = 1'b0;
  logic [7:0] cval = 8'h00;
  logic [7:0] cseq [256];

  logic [7:0] x_i [256];
  logic [7:0] x_j [256];
  logic [7:0] x_fa [256];
  logic [7:0] x_si [256];
  logic [7:0] x_sj [256];
  logic [7:0] x_d [256];
  logic [7:0] x_s [256];

  always @(posedge clk) begin
    if (ld_en) begin
      smem <= ld_s;
      emem <= ld_e;
      dmem <= ld_d;
    end else begin
      if (bus.write_en_s) smem[bus.address_s] <= bus.data;
      if (bus.write_en_d) dmem[bus.address_e] <= bus.data;
    end
    s_rd <= smem[bus.address_s];
    e_rd <= emem[bus.address_e];
  end

  assign bus.read_data         = cmode ? cval : s_rd;
  assign bus.read_encrypt_data = cmode ? cval : e_rd;

  task automatic build_model();
    logic [7:0] s [256];
    int ii, jj, si, sj, fa, fv, ev;
    s  = ld_s;
    ii = 0;
    jj = 0;
    for (int unsigned n = 0; n < MSG_LEN; n++) begin
      ii = (ii + 1) % 256;
      if (cmode) begin
        si = int'(cseq[n]);
        jj = (jj + si) % 256;
        sj = int'(cseq[n]);
        fa = (si + sj) % 256;
        fv = int'(cseq[n]);
        ev = int'(cseq[n]);
      end else begin
        si = int'(s[ii]);
        jj = (jj + si) % 256;
        sj = int'(s[jj]);
        s[ii] = 8'(sj);
        s[jj] = 8'(si);
        fa = (si + sj) % 256;
        fv = int'(s[fa]);
        ev = int'(ld_e[n]);
      end
      x_i[n]  = 8'(ii);
      x_j[n]  = 8'(jj);
      x_fa[n] = 8'(fa);
      x_si[n] = 8'(si);
      x_sj[n] = 8'(sj);
      x_d[n]  = 8'(fv ^ ev);
    end
    x_s = s;
  endtask

  task automatic load_mem();
    int r;
    logic [7:0] t;
    for (int unsigned a = 0; a < 256; a++) begin
      ld_s[a] = 8'(a);
      ld_e[a] = 8'($urandom_range(255, 0));
    end
    for (int unsigned a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      t = ld_s[a];
      ld_s[a] = ld_s[r];
      ld_s[r] = t;
    end
    build_model();
    for (int unsigned a = 0; a < 256; a++)
      ld_d[a] = (a < MSG_LEN) ? (x_d[a] ^ 8'h55) : 8'h00;
    @(negedge clk);
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_job(input bit stray, input string tag);
    int o, n, wd_pulses, sdiff;
    bit busy;
    wd_pulses = 0;
    if (cmode) cval = cseq[0];
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < JOB_CYC + 12; c++) begin
      o    = c % BYTE_CYC;
      n    = c / BYTE_CYC;
      busy = (c < JOB_CYC);
      tests++;
      if (bus.finished !== !busy) begin
        fails++;
        $display("FAIL %s finished c=%0d: got %b expected %b", tag, c, bus.finished, !busy);
      end
      tests++;
      if (bus.write_en_s !== (busy && (o == 7 || o == 8))) begin
        fails++;
        $display("FAIL %s write_en_s c=%0d: got %b expected %b", tag, c, bus.write_en_s, busy && (o == 7 || o == 8));
      end
      tests++;
      if (bus.write_en_d !== (busy && o == 12)) begin
        fails++;
        $display("FAIL %s write_en_d c=%0d: got %b expected %b", tag, c, bus.write_en_d, busy && o == 12);
      end
      if (busy && o == 1) begin
        tests++;
        if (bus.address_s !== x_i[n]) begin
          fails++;
          $display("FAIL %s read_i byte %0d: got %h expected %h", tag, n, bus.address_s, x_i[n]);
        end
      end
      if (busy && o == 4) begin
        tests++;
        if (bus.address_s !== x_j[n]) begin
          fails++;
          $display("FAIL %s read_j byte %0d: got %h expected %h", tag, n, bus.address_s, x_j[n]);
        end
      end
      if (busy && o == 9) begin
        tests++;
        if (bus.address_s !== x_fa[n]) begin
          fails++;
          $display("FAIL %s read_f byte %0d: got %h expected %h", tag, n, bus.address_s, x_fa[n]);
        end
      end
      if (busy && o == 7) begin
        tests++;
        if ({bus.address_s, bus.data} !== {x_i[n], x_sj[n]}) begin
          fails++;
          $display("FAIL %s swap_i byte %0d: got %h/%h expected %h/%h", tag, n, bus.address_s, bus.data, x_i[n], x_sj[n]);
        end
      end
      if (busy && o == 8) begin
        tests++;
        if ({bus.address_s, bus.data} !== {x_j[n], x_si[n]}) begin
          fails++;
          $display("FAIL %s swap_j byte %0d: got %h/%h expected %h/%h", tag, n, bus.address_s, bus.data, x_j[n], x_si[n]);
        end
      end
      if (busy && o == 12) begin
        tests++;
        if ({bus.address_e, bus.data} !== {8'(n), x_d[n]}) begin
          fails++;
          $display("FAIL %s dec_write byte %0d: got %h/%h expected %h/%h", tag, n, bus.address_e, bus.data, 8'(n), x_d[n]);
        end
      end
      if (bus.write_en_d === 1'b1) wd_pulses++;
      bus.start = (stray && (c == 25 || c == 200 || c == JOB_CYC - 30)) ? 1'b1 : 1'b0;
      if (cmode && busy && o == 13 && n + 1 < int'(MSG_LEN)) cval = cseq[n + 1];
      @(negedge clk);
    end
    bus.start = 1'b0;
    tests++;
    if (wd_pulses != int'(MSG_LEN)) begin
      fails++;
      $display("FAIL %s dec_pulses: got %0d expected %0d", tag, wd_pulses, MSG_LEN);
    end
    for (int unsigned a = 0; a < MSG_LEN; a++) begin
      tests++;
      if (dmem[a] !== x_d[a]) begin
        fails++;
        $display("FAIL %s dec_ram[%0d]: got %h expected %h", tag, a, dmem[a], x_d[a]);
      end
    end
    if (!cmode) begin
      sdiff = 0;
      for (int unsigned a = 0; a < 256; a++)
        if (smem[a] !== x_s[a]) sdiff++;
      tests++;
      if (sdiff != 0) begin
        fails++;
        $display("FAIL %s s_ram_final: got %0d differing entries expected 0", tag, sdiff);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.finished, bus.write_en_s, bus.write_en_d} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000", {bus.finished, bus.write_en_s, bus.write_en_d});
    end
    tests++;
    if ({bus.data, bus.address_s, bus.address_e} !== 24'h0) begin
      fails++;
      $display("FAIL reset_bus: got %h expected 000000", {bus.data, bus.address_s, bus.address_e});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.finished, bus.write_en_s, bus.write_en_d} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b expected 000", {bus.finished, bus.write_en_s, bus.write_en_d});
    end
  endtask

  task automatic test_const_stream();
    cmode = 1'b1;
    for (int unsigned a = 0; a < 256; a++) cseq[a] = (a < 2) ? 8'hA0 : 8'hAF;
    load_mem();
    run_job(1'b0, "const");
  endtask

  task automatic test_restart_random();
    cmode = 1'b0;
    load_mem();
    run_job(1'b0, "restart");
  endtask

  task automatic test_ignore_start();
    cmode = 1'b0;
    load_mem();
    run_job(1'b1, "ignore");
  endtask

  task automatic test_reset_midrun();
    int act;
    cmode = 1'b0;
    load_mem();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.finished, bus.write_en_s, bus.write_en_d} !== 3'b000) begin
      fails++;
      $display("FAIL midrun_reset_ctrl: got %b expected 000", {bus.finished, bus.write_en_s, bus.write_en_d});
    end
    tests++;
    if ({bus.data, bus.address_s, bus.address_e} !== 24'h0) begin
      fails++;
      $display("FAIL midrun_reset_bus: got %h expected 000000", {bus.data, bus.address_s, bus.address_e});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if ({bus.finished, bus.write_en_s, bus.write_en_d} !== 3'b000) act++;
    end
    tests++;
    if (act != 0) begin
      fails++;
      $display("FAIL midrun_reset_idle: got %0d active cycles expected 0", act);
    end
  endtask

  task automatic test_back_to_back();
    cmode = 1'b0;
    load_mem();
    run_job(1'b0, "b2b_a");
    load_mem();
    run_job(1'b0, "b2b_b");
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_const_stream();
    test_restart_random();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
